mmio_io_ctrl: RTL and testbench

//  Memory-mapped I/O slave downstream of the memory controller's address decode. Serves the

---
 rtl/mmio_io_ctrl_pkg.sv | 63 ++++++
 rtl/mmio_io_ctrl_if.sv | 24 ++
 rtl/mmio_io_ctrl_sseg_scanner.sv | 51 +++++
 rtl/mmio_io_ctrl.sv | 134 +++++++++++++
 tb/tb_mmio_io_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_io_ctrl_pkg.sv
// Shared constants, register decode and helpers for the switch/LED/seven-segment MMIO block.
// Word addresses, byte-lane merge and the active-low hex glyph table live here.
package mmio_io_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int WORD_ALIGN = 2;

  localparam logic [DATA_WIDTH-1:0] SWITCH_BASE_ADDR = 32'h0000_2000;
  localparam logic [DATA_WIDTH-1:0] LED_BASE_ADDR    = 32'h0000_2004;
  localparam logic [DATA_WIDTH-1:0] SSEG_BASE_ADDR   = 32'h0000_2008;

  typedef enum logic [1:0] {
    IO_SWITCH = 2'd0,
    IO_LED    = 2'd1,
    IO_SSEG   = 2'd2,
    IO_NONE   = 2'd3
  } io_reg_e;

  // Byte offset bits are ignored: any byte address inside a word selects that word.
  function automatic io_reg_e decode_word(input logic [DATA_WIDTH-1:WORD_ALIGN] word);
    if (word == SWITCH_BASE_ADDR[DATA_WIDTH-1:WORD_ALIGN]) return IO_SWITCH;
    if (word == LED_BASE_ADDR[DATA_WIDTH-1:WORD_ALIGN])    return IO_LED;
    if (word == SSEG_BASE_ADDR[DATA_WIDTH-1:WORD_ALIGN])   return IO_SSEG;
    return IO_NONE;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] be_merge(input logic [DATA_WIDTH-1:0] old_v,
                                                     input logic [DATA_WIDTH-1:0] new_v,
                                                     input logic [DATA_BYTES-1:0] be);
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // Segment order {g,f,e,d,c,b,a}, a 0 lights the segment.
  function automatic logic [6:0] hex_to_sseg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// Request/completion bus between the memory controller's I/O decode and the I/O slave.
// The master issues one request per io_sel cycle; the slave answers with a one-cycle io_ready.
interface mmio_io_ctrl_if;
  import mmio_io_ctrl_pkg::*;

  logic                  io_sel;
  logic                  io_we;
  logic [DATA_WIDTH-1:0] io_addr;
  logic [DATA_WIDTH-1:0] io_wdata;
  logic [DATA_BYTES-1:0] io_be;
  logic [DATA_WIDTH-1:0] io_rdata;
  logic                  io_ready;
  logic                  io_err;

  modport master (
    output io_sel, io_we, io_addr, io_wdata, io_be,
    input  io_rdata, io_ready, io_err
  );

  modport slave (
    input  io_sel, io_we, io_addr, io_wdata, io_be,
    output io_rdata, io_ready, io_err
  );
endinterface

// File: rtl/mmio_io_ctrl_sseg_scanner.sv
// Time-multiplexes a 32-bit hex word onto NUM_DIGITS seven-segment digits.
// Anode and segment outputs are registered and track sseg_i every cycle, not only on digit change.
module mmio_io_ctrl_sseg_scanner
  import mmio_io_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_CYCLES = 100_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sseg_i,
  output logic [NUM_DIGITS-1:0] an_n_o,
  output logic [6:0]            seg_n_o
);

  localparam int CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  wrap;

  assign wrap = (cnt_q == CNT_W'(SCAN_CYCLES - 1));

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (wrap) idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    an_n_d  = ~(NUM_DIGITS'(1) << idx_q);
    seg_n_d = hex_to_sseg(sseg_i[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      an_n_q  <= '1;
      seg_n_q <= 7'h7F;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
    end
  end

  assign an_n_o  = an_n_q;
  assign seg_n_o = seg_n_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO slave for the SWITCH, LED and SSEG words: bus registers, switch debounce and display scan.
// Every sampled request completes exactly one cycle later; writes are visible to the next request.
module mmio_io_ctrl
  import mmio_io_ctrl_pkg::*;
#(
  parameter int NUM_SWITCHES    = 16,
  parameter int NUM_LEDS        = 16,
  parameter int NUM_DIGITS      = 8,
  parameter int SCAN_CYCLES     = 100_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mmio_io_ctrl_if.slave           bus,
  input  logic [NUM_SWITCHES-1:0] sw_in,
  output logic [NUM_LEDS-1:0]     led_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [NUM_LEDS-1:0]     led_q, led_d;
  logic [DATA_WIDTH-1:0]   sseg_q, sseg_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   led_full;
  io_reg_e                 reg_sel;

  logic [NUM_SWITCHES-1:0] sync1_q, sync2_q;
  logic [NUM_SWITCHES-1:0] samp_q, samp_d;
  logic [NUM_SWITCHES-1:0] sw_stable_q, sw_stable_d;
  logic [NUM_SWITCHES-1:0] agree;
  logic [DB_W-1:0]         db_cnt_q, db_cnt_d;
  logic                    tick;

  logic                    unused_bits;

  assign reg_sel  = decode_word(bus.io_addr[DATA_WIDTH-1:WORD_ALIGN]);
  assign led_full = be_merge(DATA_WIDTH'(led_q), bus.io_wdata, bus.io_be);

  // Write completions and errors return zero data; reads return the register seen this cycle.
  always_comb begin
    led_d   = led_q;
    sseg_d  = sseg_q;
    rdata_d = rdata_q;
    ready_d = bus.io_sel;
    err_d   = 1'b0;
    if (bus.io_sel) begin
      rdata_d = '0;
      case (reg_sel)
        IO_SWITCH: begin
          if (bus.io_we) err_d = 1'b1;
          else           rdata_d = DATA_WIDTH'(sw_stable_q);
        end
        IO_LED: begin
          if (bus.io_we) led_d = led_full[NUM_LEDS-1:0];
          else           rdata_d = DATA_WIDTH'(led_q);
        end
        IO_SSEG: begin
          if (bus.io_we) sseg_d = be_merge(sseg_q, bus.io_wdata, bus.io_be);
          else           rdata_d = sseg_q;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= '0;
      sseg_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      led_q   <= led_d;
      sseg_q  <= sseg_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // A bit only moves when two consecutive tick samples agree, so glitches shorter
  // than one tick period can never reach sw_stable.
  assign tick  = (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
  assign agree = ~(sync2_q ^ samp_q);

  always_comb begin
    db_cnt_d    = tick ? '0 : db_cnt_q + 1'b1;
    samp_d      = tick ? sync2_q : samp_q;
    sw_stable_d = sw_stable_q;
    if (tick) sw_stable_d = (sw_stable_q & ~agree) | (sync2_q & agree);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      samp_q      <= '0;
      sw_stable_q <= '0;
      db_cnt_q    <= '0;
    end else begin
      sync1_q     <= sw_in;
      sync2_q     <= sync1_q;
      samp_q      <= samp_d;
      sw_stable_q <= sw_stable_d;
      db_cnt_q    <= db_cnt_d;
    end
  end

  mmio_io_ctrl_sseg_scanner #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_CYCLES (SCAN_CYCLES)
  ) u_scanner (
    .clk     (clk),
    .rst_n   (rst_n),
    .sseg_i  (sseg_q),
    .an_n_o  (an_n),
    .seg_n_o (seg_n)
  );

  assign bus.io_rdata = rdata_q;
  assign bus.io_ready = ready_q;
  assign bus.io_err   = err_q;
  assign led_out      = led_q;
  assign dp_n         = 1'b1;

  assign unused_bits = ^{bus.io_addr[WORD_ALIGN-1:0], led_full};

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl: requests push expectations into a queue and a
// separate monitor pops one entry per io_ready pulse.
module tb_mmio_io_ctrl;
  import mmio_io_ctrl_pkg::*;

  localparam logic [31:0] A_SW   = 32'h0000_2000;
  localparam logic [31:0] A_LED  = 32'h0000_2004;
  localparam logic [31:0] A_SSEG = 32'h0000_2008;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] alt;
    bit          alt_ok;
    bit          err;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb[$];

  // Hand-written active-low glyphs {g,f,e,d,c,b,a} for 0..F.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  mmio_io_ctrl_if bus();

  mmio_io_ctrl #(
    .NUM_SWITCHES    (16),
    .NUM_LEDS        (16),
    .NUM_DIGITS      (8),
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sw_in   (sw_in),
    .led_out (led_out),
    .an_n    (an_n),
    .seg_n   (seg_n),
    .dp_n    (dp_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata, input bit exp_err,
                       input string name, input bit alt_ok, input logic [31:0] alt);
    exp_t e;
    bus.io_sel   = 1'b1;
    bus.io_we    = we;
    bus.io_addr  = addr;
    bus.io_wdata = wdata;
    bus.io_be    = be;
    e.rdata = exp_rdata; e.alt = alt; e.alt_ok = alt_ok; e.err = exp_err; e.name = name;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                    input bit exp_err, input string name);
    issue(1'b1, addr, wdata, be, 32'h0, exp_err, name, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rdata, input bit exp_err,
                    input string name);
    issue(1'b0, addr, 32'h0, 4'h0, exp_rdata, exp_err, name, 1'b0, 32'h0);
  endtask

  task automatic idle(input int n);
    bus.io_sel = 1'b0;
    bus.io_we  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: one scoreboard entry per completion pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.io_ready === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_completion: rdata %h err %b with nothing outstanding",
                   bus.io_rdata, bus.io_err);
        end else begin
          e = sb.pop_front();
          if (((bus.io_rdata === e.rdata) || (e.alt_ok && bus.io_rdata === e.alt)) &&
              (bus.io_err === e.err)) n_pass++;
          else $display("FAIL %s: got rdata %h err %b expected rdata %h err %b at %0t",
                        e.name, bus.io_rdata, bus.io_err, e.rdata, e.err, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] scan_val;
    int dwell, prev, segs, idx;
    bit saw_wrap;

    bus.io_sel = 1'b0; bus.io_we = 1'b0; bus.io_addr = '0; bus.io_wdata = '0; bus.io_be = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Populate state, then reset mid-scan while a write is being sampled.
    wr(A_SSEG, 32'h1234_5678, 4'hF, 1'b0, "wr_sseg_pre");
    wr(A_LED, 32'h0000_5A5A, 4'hF, 1'b0, "wr_led_pre");
    rd(A_SSEG, 32'h1234_5678, 1'b0, "rd_sseg_pre");
    idle(5);
    chk("led_pre", 32'(led_out), 32'h5A5A);
    bus.io_sel = 1'b1; bus.io_we = 1'b1; bus.io_addr = A_LED;
    bus.io_wdata = 32'h0000_FFFF; bus.io_be = 4'hF;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_an_n", 32'(an_n), 32'hFF);
    chk("rst_seg_n", 32'(seg_n), 32'h7F);
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_ready", 32'(bus.io_ready), 32'h0);
    chk("rst_err", 32'(bus.io_err), 32'h0);
    chk("rst_rdata", bus.io_rdata, 32'h0);
    chk("dp_n", 32'(dp_n), 32'h1);
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    rd(A_SSEG, 32'h0, 1'b0, "rd_sseg_after_rst");
    rd(A_LED, 32'h0, 1'b0, "rd_led_after_rst");
    idle(1);

    // LED byte enables and width masking.
    wr(A_LED, 32'h0000_A5A5, 4'b0011, 1'b0, "wr_led_a5a5");
    idle(1);
    chk("led_a5a5", 32'(led_out), 32'hA5A5);
    chk("ready_one_cycle", 32'(bus.io_ready), 32'h0);
    wr(A_LED, 32'hFFFF_0000, 4'b1100, 1'b0, "wr_led_upper_be");
    idle(1);
    chk("led_unchanged", 32'(led_out), 32'hA5A5);
    rd(A_LED, 32'h0000_A5A5, 1'b0, "rd_led_a5a5");
    wr(A_LED, 32'h0000_00FF, 4'b0001, 1'b0, "wr_led_byte0");
    rd(A_LED + 32'd1, 32'h0000_A5FF, 1'b0, "rd_led_byte_offset");
    wr(A_LED, 32'hFFFF_FFFF, 4'hF, 1'b0, "wr_led_all");
    rd(A_LED, 32'h0000_FFFF, 1'b0, "rd_led_masked");
    idle(3);
    chk("rdata_holds", bus.io_rdata, 32'h0000_FFFF);

    // SSEG partial write, then back-to-back write/read and a full scan.
    wr(A_SSEG, 32'h1200_0000, 4'b1000, 1'b0, "wr_sseg_byte3");
    rd(A_SSEG, 32'h1200_0000, 1'b0, "rd_sseg_byte3");
    wr(A_SSEG, 32'h89AB_CDEF, 4'hF, 1'b0, "wr_sseg_b2b");
    rd(A_SSEG, 32'h89AB_CDEF, 1'b0, "rd_sseg_b2b");
    idle(1);
    scan_val = 32'h89AB_CDEF;
    dwell = 0; prev = -1; segs = 0; saw_wrap = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      idx = -1;
      for (int d = 0; d < 8; d++) if (an_n == ~(8'd1 << d)) idx = d;
      if (idx < 0) begin
        n_checks++;
        $display("FAIL an_onehot: got %h expected one-hot-low", an_n);
      end else begin
        chk("seg_glyph", 32'(seg_n), 32'(glyph[scan_val[idx*4 +: 4]]));
        if (idx != prev) begin
          if (prev >= 0) begin
            chk("anode_step", 32'(idx), 32'((prev + 1) % 8));
            if (segs > 0) chk("anode_dwell", 32'(dwell), 32'd4);
            if (prev == 7) saw_wrap = 1'b1;
            segs++;
          end
          dwell = 1;
          prev  = idx;
        end else begin
          dwell++;
        end
      end
    end
    chk("scan_wrapped", 32'(saw_wrap), 32'h1);

    wr(A_SSEG, 32'h0, 4'hF, 1'b0, "wr_sseg_zero");
    idle(1);
    chk("glyph_fast_update", 32'(seg_n), 32'h40);

    // Switch glitch, then reads that must only ever see 0 or the settled value.
    sw_in = 16'hFFFF;
    repeat (3) @(negedge clk);
    sw_in = 16'h1234;
    for (int k = 0; k < 18; k++)
      issue(1'b0, A_SW, 32'h0, 4'h0, 32'h0000_1234, 1'b0, "rd_sw_settling", 1'b1, 32'h0);
    rd(A_SW, 32'h0000_1234, 1'b0, "rd_sw_settled");
    idle(1);

    // Error cases leave state untouched.
    rd(32'h0000_200C, 32'h0, 1'b1, "rd_unmapped");
    wr(A_SW, 32'hFFFF_FFFF, 4'hF, 1'b1, "wr_switch_err");
    rd(A_SW, 32'h0000_1234, 1'b0, "rd_sw_after_err");
    wr(32'h0000_3004, 32'h0, 4'hF, 1'b1, "wr_unmapped_hi");
    rd(A_LED, 32'h0000_FFFF, 1'b0, "rd_led_after_err");
    idle(4);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
